// File: rtl/scan_pkg.sv
// Shared types for the scan-chain driver: controller states, shift phase,
// and the counter-width helper used by the bit sequencer.
package scan_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        VERIFY,
        DONE
    } state_t;

    // PH_LOW presents data with scan_clk low, PH_HIGH raises scan_clk.
    typedef enum logic {
        PH_LOW,
        PH_HIGH
    } phase_t;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/scan_bit_seq.sv
// Bit sequencer: walks k = 0..N-1 with two phases per bit and selects
// seq[k] = image[N-1-k]. Next-cycle values are exported so the driver can
// register its outputs in step with this counter.
module scan_bit_seq
    import scan_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         step,
    input  logic [N-1:0] image,
    output phase_t       phase,
    output logic         last,
    output phase_t       phase_nxt,
    output logic         bit_nxt
);

    localparam int unsigned KW = cnt_width(N);

    logic [KW-1:0] k;
    logic [KW-1:0] k_nxt;

    // Phase toggle and bit advance; the final bit wraps k back to 0.
    always_comb begin
        last      = (k == KW'(N - 1)) && (phase == PH_HIGH);
        k_nxt     = k;
        phase_nxt = phase;
        if (clear) begin
            k_nxt     = '0;
            phase_nxt = PH_LOW;
        end else if (step) begin
            if (phase == PH_LOW) begin
                phase_nxt = PH_HIGH;
            end else begin
                phase_nxt = PH_LOW;
                k_nxt     = last ? '0 : k + 1'b1;
            end
        end
        bit_nxt = image[KW'(N - 1) - k_nxt];
    end

    // Counter and phase registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            k     <= '0;
            phase <= PH_LOW;
        end else begin
            k     <= k_nxt;
            phase <= phase_nxt;
        end
    end

endmodule

// File: rtl/scan_driver.sv
// Scan-chain programmer: shifts a latched L x B image into an external
// chain (MSB word/bit first), optionally replays it while comparing the
// chain tail, and reports completion with a one-cycle done pulse.
module scan_driver
    import scan_pkg::*;
#(
    parameter int unsigned L         = 4,
    parameter int unsigned B         = 8,
    parameter bit          VERIFY_EN = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [L-1:0][B-1:0] cfg,
    input  logic                scan_q,
    output logic                scan_clk,
    output logic                scan_din,
    output logic                busy,
    output logic                done,
    output logic                mismatch
);

    localparam int unsigned N = L * B;

    state_t       state;
    state_t       state_n;
    logic [N-1:0] image;
    logic [N-1:0] image_nxt;
    logic         accept;
    logic         step;
    logic         busy_nxt;
    logic         last;
    logic         bit_nxt;
    phase_t       phase;
    phase_t       phase_nxt;

    // The sequencer sees the image as it will be next cycle, so the first
    // bit comes straight from cfg on the accepting edge.
    scan_bit_seq #(
        .N(N)
    ) u_seq (
        .clk       (clk),
        .rst       (rst),
        .clear     (accept),
        .step      (step),
        .image     (image_nxt),
        .phase     (phase),
        .last      (last),
        .phase_nxt (phase_nxt),
        .bit_nxt   (bit_nxt)
    );

    // Next-state logic and next-cycle output terms.
    always_comb begin
        state_n = state;
        accept  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_n = LOAD;
                end
            end
            LOAD: begin
                if (last) begin
                    if (VERIFY_EN) state_n = VERIFY;
                    else           state_n = DONE;
                end
            end
            VERIFY: begin
                if (last) state_n = DONE;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        step      = (state == LOAD) || (state == VERIFY);
        busy_nxt  = (state_n == LOAD) || (state_n == VERIFY);
        image_nxt = accept ? cfg : image;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Registered outputs, image latch and sticky readback compare.
    always_ff @(posedge clk) begin
        if (rst) begin
            image    <= '0;
            scan_clk <= 1'b0;
            scan_din <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            mismatch <= 1'b0;
        end else begin
            image    <= image_nxt;
            busy     <= busy_nxt;
            done     <= (state_n == DONE);
            scan_clk <= busy_nxt && (phase_nxt == PH_HIGH);
            scan_din <= busy_nxt ? bit_nxt : 1'b0;
            // During VERIFY phase 0 scan_din already carries seq[k].
            if (accept) begin
                mismatch <= 1'b0;
            end else if ((state == VERIFY) && (phase == PH_LOW) && (scan_q != scan_din)) begin
                mismatch <= 1'b1;
            end
        end
    end

endmodule

// File: doc/scan_driver.md
SCAN_DRIVER -- requirements
Module: scan_driver

Interface
REQ-001 SHALL have parameter L, default 4, meaning number of chain words.
REQ-002 SHALL have parameter B, default 8, meaning bits per chain word.
REQ-003 SHALL have parameter VERIFY_EN, default 1, meaning a readback pass follows the load pass.
REQ-004 SHALL have ports clk input 1, the single system clock, and rst input 1, synchronous active-high reset.
REQ-005 SHALL have ports: start input 1, load request; cfg input [L-1:0][B-1:0], parallel image to program; scan_q input 1, chain tail (q_out of the chain).
REQ-006 SHALL have ports: scan_clk output 1, chain clock; scan_din output 1, chain head data; busy output 1; done output 1, one-cycle pulse; mismatch output 1, sticky readback error.

Function
REQ-007 N = L*B; bit counter width = $clog2(N) (minimum 1); shift sequence seq[k] = cfg bit at flat index N-1-k, i.e. cfg[L-1][B-1] first and cfg[0][0] last, so each bit lands at its own chain index.
REQ-008 States: IDLE, LOAD, VERIFY, DONE; busy = 1 in LOAD and VERIFY only.
REQ-009 IDLE: start=1 latches cfg into an internal image, clears mismatch, and enters LOAD with k=0, phase 0 on the next cycle; start is ignored outside IDLE.
REQ-010 Each bit takes 2 clk cycles: phase 0 has scan_clk=0 and scan_din=seq[k]; phase 1 has scan_clk=1 and scan_din held; all outputs registered.
REQ-011 LOAD: after phase 1 of k=N-1, go to VERIFY with k=0 if VERIFY_EN=1, else to DONE; LOAD lasts exactly 2N cycles.
REQ-012 VERIFY: scan_din replays seq[k] with the same timing; scan_q is sampled on the clk edge ending phase 0 and compared to seq[k]; any inequality sets mismatch; VERIFY lasts 2N cycles and leaves the chain holding the image.
REQ-013 DONE: lasts one cycle with done=1 and scan_clk=0, then returns to IDLE; start in DONE is ignored.
REQ-014 mismatch holds its value through IDLE until the next accepted start; in the load-only mode (VERIFY_EN=0), mismatch stays 0.
REQ-015 scan_clk SHALL be 0 in IDLE and DONE; no scan_clk edge occurs outside LOAD/VERIFY phase transitions.
REQ-016 Changes to cfg during busy have no effect: the latched image is used.

Reset
REQ-017 rst=1 at any clk edge SHALL force IDLE, scan_clk=0, scan_din=0, busy=0, done=0, mismatch=0, k=0, phase 0.
REQ-018 Reset during LOAD/VERIFY aborts immediately with no further scan_clk edges; chain contents are then undefined, and no done pulse is issued.

Structure
REQ-019 Package scan_pkg SHALL hold the state enum (IDLE, LOAD, VERIFY, DONE) and the phase type.
REQ-020 One sub-module, scan_bit_seq, SHALL hold the bit counter, phase toggle and seq[k] mux; the FSM and compare stay in scan_driver.

Verification (bench: scan_driver connected to the existing L=2, B=4 scan chain; N=8; start pulsed at cycle 0)
REQ-021 cfg=8'hA5 with VERIFY_EN=1 -> busy is high for cycles 1-32, done pulses at cycle 33, the chain holds q=A5, and mismatch=0.
REQ-022 Same run with scan_q forced to 0 during VERIFY -> mismatch=1 from the first sample where seq[k]=1, held after done and cleared on the next start.
REQ-023 VERIFY_EN=0, cfg=8'h3C -> done pulses at cycle 17, exactly 8 scan_clk rising edges occur, and the chain holds 3C.
REQ-024 rst asserted at cycle 9 -> next cycle IDLE with scan_clk=0, busy=0 and no done pulse; a following start with cfg=8'hFF completes with mismatch=0.
REQ-025 start re-pulsed at cycle 5 and cfg changed to 8'h00 mid-run -> both are ignored and the chain ends with the original image.
